// File: rtl/proj_pkg.sv
// rtl/proj_pkg.sv - shared constants and types for the k-mer buffer / MinHash datapath
package proj_pkg;

  localparam int KMER_BUFFER_HASHER_KMER_LEN  = 16;
  localparam int KMER_BUFFER_HASHER_BASE_BITS = 2;

  typedef logic [31:0] hash_word_t;

  localparam hash_word_t MURMUR_C1           = 32'hCC9E2D51;
  localparam hash_word_t MURMUR_C2           = 32'h1B873593;
  localparam hash_word_t MURMUR_N            = 32'hE6546B64;
  localparam hash_word_t MURMUR_M            = 32'd5;
  localparam hash_word_t FMIX_C1             = 32'h85EBCA6B;
  localparam hash_word_t FMIX_C2             = 32'hC2B2AE35;
  localparam hash_word_t MURMUR_SEED_DEFAULT = 32'h9747B28C;

endpackage

// File: rtl/murmur_round.sv
// rtl/murmur_round.sv - one registered Murmur3 block round: h <= rol(h ^ k, 13) * 5 + n
module murmur_round
  import proj_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  hash_word_t i_h,
  input  hash_word_t i_k,
  output hash_word_t o_h
);

  hash_word_t w_x;
  hash_word_t r_h;

  assign w_x = i_h ^ i_k;
  assign o_h = r_h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
    end else if (i_en) begin
      r_h <= {w_x[18:0], w_x[31:19]} * MURMUR_M + MURMUR_N;
    end
  end

endmodule

// File: rtl/murmur_hasher_pipe.sv
// rtl/murmur_hasher_pipe.sv - pipelined multi-seed MurmurHash3 x86_32 engine for MinHash
// MURMUR_HASHER_FMIX_EN appends the two-stage Murmur3 finalizer (LAT = NUM_BLOCKS + 3, else NUM_BLOCKS + 1)
module murmur_hasher_pipe
  import proj_pkg::*;
#(
  parameter int  KMER_LEN   = KMER_BUFFER_HASHER_KMER_LEN,
  parameter int  BASE_BITS  = KMER_BUFFER_HASHER_BASE_BITS,
  parameter int  NUM_SEEDS  = 4,
  parameter int  TAG_BITS   = 8,
  localparam int KMER_BITS  = KMER_LEN * BASE_BITS,
  localparam int NUM_BLOCKS = (KMER_BITS + 31) / 32,
  localparam int SEED_IDX_W = (NUM_SEEDS > 1) ? $clog2(NUM_SEEDS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [KMER_BITS-1:0]    in_kmer,
  input  logic [TAG_BITS-1:0]     in_tag,
  input  logic                    seed_we,
  input  logic [SEED_IDX_W-1:0]   seed_idx,
  input  logic [31:0]             seed_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_SEEDS*32-1:0] out_sig,
  output logic [TAG_BITS-1:0]     out_tag
);

  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  hash_word_t r_seed [NUM_SEEDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_SEEDS; j++) r_seed[j] <= MURMUR_SEED_DEFAULT + hash_word_t'(j);
    end else if (seed_we && (int'(seed_idx) < NUM_SEEDS)) begin
      r_seed[seed_idx] <= seed_data;
    end
  end

  logic [NUM_BLOCKS*32-1:0] w_kmer_pad;
  hash_word_t               w_k [NUM_BLOCKS];

  always_comb begin
    w_kmer_pad = '0;
    w_kmer_pad[KMER_BITS-1:0] = in_kmer;
  end

  // k is seed-independent, so one copy per block feeds every channel
  for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_kcalc
    hash_word_t w_m;
    assign w_m    = w_kmer_pad[32*b +: 32] * MURMUR_C1;
    assign w_k[b] = {w_m[16:0], w_m[31:17]} * MURMUR_C2;
  end

  // r_vld/r_tag[0] is stage K, index s is round stage H_s; r_kk[s] carries k words to H_(s+1)
  logic                r_vld    [NUM_BLOCKS+1];
  logic [TAG_BITS-1:0] r_tag    [NUM_BLOCKS+1];
  hash_word_t          r_kk     [NUM_BLOCKS][NUM_BLOCKS];
  hash_word_t          r_k_seed [NUM_SEEDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= NUM_BLOCKS; s++) begin
        r_vld[s] <= 1'b0;
        r_tag[s] <= '0;
      end
      for (int s = 0; s < NUM_BLOCKS; s++) begin
        for (int i = 0; i < NUM_BLOCKS; i++) r_kk[s][i] <= '0;
      end
      for (int j = 0; j < NUM_SEEDS; j++) r_k_seed[j] <= '0;
    end else if (w_adv) begin
      r_vld[0]  <= in_valid;
      r_tag[0]  <= in_tag;
      r_kk[0]   <= w_k;
      r_k_seed  <= r_seed;
      for (int s = 1; s <= NUM_BLOCKS; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_tag[s] <= r_tag[s-1];
      end
      for (int s = 1; s < NUM_BLOCKS; s++) r_kk[s] <= r_kk[s-1];
    end
  end

  hash_word_t w_h [NUM_BLOCKS][NUM_SEEDS];

  for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_blk
    for (genvar j = 0; j < NUM_SEEDS; j++) begin : g_seed
      hash_word_t w_hin;
      if (b == 0) begin : g_first
        assign w_hin = r_k_seed[j];
      end else begin : g_chain
        assign w_hin = w_h[b-1][j];
      end
      murmur_round u_round (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_adv),
        .i_h   (w_hin),
        .i_k   (r_kk[b][b]),
        .o_h   (w_h[b][j])
      );
    end
  end

`ifdef MURMUR_HASHER_FMIX_EN
  localparam hash_word_t LEN_BYTES = hash_word_t'(4 * NUM_BLOCKS);

  logic                r_f1_vld;
  logic                r_f2_vld;
  logic [TAG_BITS-1:0] r_f1_tag;
  logic [TAG_BITS-1:0] r_f2_tag;
  hash_word_t          w_f1 [NUM_SEEDS];
  hash_word_t          w_f2 [NUM_SEEDS];
  hash_word_t          r_f1 [NUM_SEEDS];
  hash_word_t          r_f2 [NUM_SEEDS];

  for (genvar j = 0; j < NUM_SEEDS; j++) begin : g_fmix
    hash_word_t w_a;
    hash_word_t w_b;
    hash_word_t w_c;
    hash_word_t w_d;
    assign w_a     = w_h[NUM_BLOCKS-1][j] ^ LEN_BYTES;
    assign w_b     = w_a ^ (w_a >> 16);
    assign w_f1[j] = w_b * FMIX_C1;
    assign w_c     = r_f1[j] ^ (r_f1[j] >> 13);
    assign w_d     = w_c * FMIX_C2;
    assign w_f2[j] = w_d ^ (w_d >> 16);
    assign out_sig[32*j +: 32] = r_f2[j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f1_vld <= 1'b0;
      r_f2_vld <= 1'b0;
      r_f1_tag <= '0;
      r_f2_tag <= '0;
      for (int j = 0; j < NUM_SEEDS; j++) begin
        r_f1[j] <= '0;
        r_f2[j] <= '0;
      end
    end else if (w_adv) begin
      r_f1_vld <= r_vld[NUM_BLOCKS];
      r_f1_tag <= r_tag[NUM_BLOCKS];
      r_f1     <= w_f1;
      r_f2_vld <= r_f1_vld;
      r_f2_tag <= r_f1_tag;
      r_f2     <= w_f2;
    end
  end

  assign out_valid = r_f2_vld;
  assign out_tag   = r_f2_tag;
`else
  for (genvar j = 0; j < NUM_SEEDS; j++) begin : g_raw
    assign out_sig[32*j +: 32] = w_h[NUM_BLOCKS-1][j];
  end

  assign out_valid = r_vld[NUM_BLOCKS];
  assign out_tag   = r_tag[NUM_BLOCKS];
`endif

endmodule

// File: tb/tb_murmur_hasher_pipe.sv
// tb/tb_murmur_hasher_pipe.sv - randomized scoreboard bench for murmur_hasher_pipe
module tb_murmur_hasher_pipe;

  localparam int NS  = 4;
  localparam int NS2 = 3;
`ifdef MURMUR_HASHER_FMIX_EN
  localparam int LAT1 = 4;
  localparam int LAT2 = 5;
  localparam bit FMIX = 1'b1;
`else
  localparam int LAT1 = 2;
  localparam int LAT2 = 3;
  localparam bit FMIX = 1'b0;
`endif
  localparam logic [31:0] SEED_DEF = 32'h9747B28C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           in_valid, in_ready, seed_we, out_valid, out_ready;
  logic [31:0]    in_kmer, seed_data;
  logic [7:0]     in_tag, out_tag;
  logic [1:0]     seed_idx;
  logic [NS*32-1:0] out_sig;

  logic           v2_in_valid, v2_in_ready, v2_seed_we, v2_out_valid, v2_out_ready;
  logic [61:0]    v2_in_kmer;
  logic [31:0]    v2_seed_data;
  logic [7:0]     v2_in_tag, v2_out_tag;
  logic [1:0]     v2_seed_idx;
  logic [NS2*32-1:0] v2_out_sig;

  murmur_hasher_pipe u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_kmer(in_kmer), .in_tag(in_tag),
    .seed_we(seed_we), .seed_idx(seed_idx), .seed_data(seed_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sig(out_sig), .out_tag(out_tag)
  );

  murmur_hasher_pipe #(.KMER_LEN(31), .NUM_SEEDS(NS2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v2_in_valid), .in_ready(v2_in_ready), .in_kmer(v2_in_kmer), .in_tag(v2_in_tag),
    .seed_we(v2_seed_we), .seed_idx(v2_seed_idx), .seed_data(v2_seed_data),
    .out_valid(v2_out_valid), .out_ready(v2_out_ready), .out_sig(v2_out_sig), .out_tag(v2_out_tag)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int r);
    return (x << r) | (x >> (32 - r));
  endfunction

  // Reference MurmurHash3_x86_32 over nblk little-endian 32-bit words (raw mix when FMIX is off)
  function automatic logic [31:0] ref_hash(input logic [31:0] seed, input logic [63:0] key, input int nblk);
    logic [31:0] h, k;
    h = seed;
    for (int i = 0; i < nblk; i++) begin
      k = key[32*i +: 32];
      k = rotl(k * 32'hCC9E2D51, 15) * 32'h1B873593;
      h = rotl(h ^ k, 13) * 32'd5 + 32'hE6546B64;
    end
    if (FMIX) begin
      h = h ^ 32'(4 * nblk);
      h = h ^ (h >> 16);
      h = h * 32'h85EBCA6B;
      h = h ^ (h >> 13);
      h = h * 32'hC2B2AE35;
      h = h ^ (h >> 16);
    end
    return h;
  endfunction

  typedef struct packed {
    logic [7:0]       tag;
    logic [NS*32-1:0] sig;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_seed [NS];
  logic        hold_pend = 1'b0;
  logic [NS*32-1:0] hold_sig;
  logic [7:0]  hold_tag;
  int          n_acc = 0;
  int          n_out = 0;

  // Inputs are already set for this cycle; evaluate handshakes, then advance one clock
  task automatic step();
    exp_t e;
    #1;
    if (hold_pend) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      for (int j = 0; j < NS; j++)
        chk($sformatf("hold_sig%0d", j), out_sig[32*j +: 32], hold_sig[32*j +: 32]);
      chk("hold_tag", 32'(out_tag), 32'(hold_tag));
    end
    hold_pend = out_valid && !out_ready;
    hold_sig  = out_sig;
    hold_tag  = out_tag;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_beat", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        n_out++;
        for (int j = 0; j < NS; j++)
          chk($sformatf("sig%0d", j), out_sig[32*j +: 32], e.sig[32*j +: 32]);
        chk("tag", 32'(out_tag), 32'(e.tag));
      end
    end
    if (in_valid && in_ready) begin
      e.tag = in_tag;
      for (int j = 0; j < NS; j++) e.sig[32*j +: 32] = ref_hash(m_seed[j], {32'd0, in_kmer}, 1);
      sb.push_back(e);
      n_acc++;
    end
    if (seed_we) m_seed[seed_idx] = seed_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    seed_we   = 1'b0;
    for (int c = 0; c < 40 && (sb.size() != 0 || out_valid); c++) step();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    int          base;
    logic [63:0] key;

    in_valid = 0; in_kmer = 0; in_tag = 0; seed_we = 0; seed_idx = 0; seed_data = 0; out_ready = 0;
    v2_in_valid = 0; v2_in_kmer = 0; v2_in_tag = 0; v2_seed_we = 0; v2_seed_idx = 0;
    v2_seed_data = 0; v2_out_ready = 1;
    for (int j = 0; j < NS; j++) m_seed[j] = SEED_DEF + 32'(j);

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    for (int j = 0; j < NS; j++) chk($sformatf("rst_sig%0d", j), out_sig[32*j +: 32], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // seed 0 on channel 0, all-zero k-mer: known vector and latency
    out_ready = 1; seed_we = 1; seed_idx = 0; seed_data = 32'd0;
    step();
    seed_we = 0; in_valid = 1; in_kmer = 32'd0; in_tag = 8'h5A;
    step();
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'(LAT1));
`ifdef MURMUR_HASHER_FMIX_EN
    chk("known_vector", out_sig[31:0], 32'h2362F9DE);
`else
    chk("known_vector", out_sig[31:0], 32'hE6546B64);
`endif
    step();

    // seed write to channel 1 in the same cycle as an accept
    in_valid = 1; in_kmer = $urandom; in_tag = 8'h11;
    seed_we = 1; seed_idx = 1; seed_data = 32'h1234_5678;
    step();
    seed_we = 0; in_kmer = $urandom; in_tag = 8'h12;
    step();
    drain();

    // 100 random beats with random backpressure and occasional seed writes
    base = n_acc;
    for (int c = 0; c < 3000 && (n_acc - base) < 100; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_kmer   = $urandom;
      in_tag    = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      seed_we   = ($urandom_range(0, 9) == 0);
      seed_idx  = 2'($urandom);
      seed_data = $urandom;
      step();
    end
    drain();
    chk("rand_accepted", 32'(n_acc - base), 32'd100);
    chk("in_out_count", 32'(n_out), 32'(n_acc));

    // reset with beats in flight and a non-default seed
    out_ready = 1; seed_we = 1; seed_idx = 2; seed_data = 32'hDEADBEEF;
    step();
    seed_we = 0; in_valid = 1;
    repeat (3) begin
      in_kmer = $urandom;
      in_tag  = 8'($urandom);
      step();
    end
    in_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", 32'(out_valid), 32'd0);
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    chk("rstmid_sig0", out_sig[31:0], 32'd0);
    sb.delete();
    hold_pend = 1'b0;
    for (int j = 0; j < NS; j++) m_seed[j] = SEED_DEF + 32'(j);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1; in_kmer = $urandom; in_tag = 8'hC3;
    step();
    drain();

    // 62-bit k-mers (two blocks); out-of-range seed index write is ignored
    v2_seed_we = 1; v2_seed_idx = 2'd3; v2_seed_data = $urandom;
    @(posedge clk);
    @(negedge clk);
    v2_seed_we = 0;
    for (int t = 0; t < 6; t++) begin
      key = {$urandom, $urandom};
      key[63:62] = 2'b00;
      v2_in_kmer = key[61:0];
      v2_in_tag = 8'(t + 8'h40);
      v2_in_valid = 1;
      #1;
      chk("k2_in_ready", 32'(v2_in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      v2_in_valid = 0;
      lat = 1;
      while (!v2_out_valid && lat < 20) begin
        @(posedge clk);
        @(negedge clk);
        lat++;
      end
      chk("k2_latency", 32'(lat), 32'(LAT2));
      for (int j = 0; j < NS2; j++)
        chk($sformatf("k2_sig%0d", j), v2_out_sig[32*j +: 32], ref_hash(SEED_DEF + 32'(j), key, 2));
      chk("k2_tag", 32'(v2_out_tag), 32'(t + 8'h40));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/murmur_hasher_pipe.md
# murmur_hasher_pipe

Pipelined, multi-seed MurmurHash3 (x86_32) engine for the MinHash datapath. Each accepted k-mer is hashed against NUM_SEEDS independent, runtime-programmable seeds in parallel, producing NUM_SEEDS 32-bit signatures per beat. It sits between the k-mer buffer and the min-signature tracker. It uses valid/ready handshakes on both sides and supports k-mers wider than 32 bits as multiple Murmur blocks.

## Interface
- KMER_LEN, default proj_pkg::KMER_BUFFER_HASHER_KMER_LEN (16): bases per k-mer.
- BASE_BITS, default proj_pkg::KMER_BUFFER_HASHER_BASE_BITS (2): bits per base.
- NUM_SEEDS, default 4: parallel hash channels, range 1..16.
- TAG_BITS, default 8: sideband tag carried alongside the data.
- Derived: KMER_BITS = KMER_LEN*BASE_BITS; NUM_BLOCKS = ceil(KMER_BITS/32).

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: input k-mer valid.
- in_ready, out, 1: block can accept an input.
- in_kmer, in, KMER_BITS: k-mer; block i = bits [32i+31:32i], zero-padded above KMER_BITS.
- in_tag, in, TAG_BITS: sideband, passed through unchanged.
- seed_we, in, 1: seed write strobe.
- seed_idx, in, $clog2(NUM_SEEDS) (minimum 1): seed register to write.
- seed_data, in, 32: new seed value.
- out_valid, out, 1: signatures valid.
- out_ready, in, 1: downstream accepts.
- out_sig, out, NUM_SEEDS*32: signature j = bits [32j+31:32j].
- out_tag, out, TAG_BITS: tag of the output beat.

## Operation
- Arithmetic is modulo 2^32 throughout. c1 = 0xCC9E2D51, c2 = 0x1B873593, n = 0xE6546B64. rol(x,r) is a 32-bit rotate left.
- Stage K (1 register stage): for every block, k_i = rol(block_i*c1, 15)*c2. The result is seed-independent and shared by all channels.
- Stages H1..H_NUM_BLOCKS, one stage per block, per seed j:
  - h = h ^ k_i
  - h = rol(h, 13)*5 + n
  - h starts from seed j.
- Seed capture: seeds are captured into stage K with the data. A later seed write never alters beats already in flight.
- Seed register file:
  - Reset value: seed j = 0x9747B28C + j.
  - A write on seed_we takes effect for inputs accepted on the next cycle or later.
  - A write and an accept in the same cycle: the accepted beat uses the old seed.
  - seed_idx ≥ NUM_SEEDS: the write is ignored.
- in_tag travels with its beat. Order is strictly preserved.
- Reset mid-operation: all in-flight beats are discarded, all valid bits are cleared, and seeds return to their defaults.

## Timing
- The pipeline is LAT stages deep:
  - LAT = 1 + NUM_BLOCKS + 2 with the macro defined.
  - LAT = 1 + NUM_BLOCKS without it.
  - Default with macro = 4; default without = 2.
- Global stall: adv = !out_valid || out_ready. When adv is low, every stage holds. in_ready = adv.
- Accept when in_valid && in_ready. The output appears exactly LAT cycles after acceptance, absent stalls.
- Throughput is one beat per cycle with out_ready held high. Bubbles propagate as invalid stages and are never compacted.
- out_valid, once high, stays high with out_sig/out_tag stable until out_ready.
- Reset values: in_ready = 1, out_valid = 0, out_sig = 0, out_tag = 0.

## Configuration
- MURMUR_HASHER_FMIX_EN defined: two extra stages append the Murmur3 finalizer.
  - Stage F1: h ^= 4*NUM_BLOCKS; h ^= h>>16; h *= 0x85EBCA6B.
  - Stage F2: h ^= h>>13; h *= 0xC2B2AE35; h ^= h>>16.
  - Output equals the reference MurmurHash3_x86_32.
- Not defined: these stages are absent. The output is the raw mix result, as the earlier hasher produced.

## Structure
- proj_pkg gains:
  - MURMUR_C1, MURMUR_C2, MURMUR_N, MURMUR_M (=5)
  - FMIX_C1, FMIX_C2
  - MURMUR_SEED_DEFAULT
  - typedef logic [31:0] hash_word_t
- One sub-module, murmur_round: a registered per-block h update (xor, rol13, *5+n) with enable. It is instantiated NUM_BLOCKS×NUM_SEEDS times.
- Rotates are pure wiring inside the top level or murmur_round. No separate rotate modules.

## Test plan
- Defaults with macro, seed 0 written to channel 0, in_kmer = 0 → 4 cycles later out_sig[31:0] = 0x2362F9DE.
- Defaults without macro, seed 0, in_kmer = 0 → 2 cycles later out_sig[31:0] = 0xE6546B64.
- Back-to-back 100 random beats, out_ready random 50% → outputs match the software model in order, tags intact, no beat lost or duplicated.
- Seed rewrite of channel 1 in the same cycle as an accept → that beat uses the old seed; the next beat uses the new seed.
- KMER_LEN = 31 (NUM_BLOCKS = 2), random k-mers → matches the 8-byte model with zero-padded upper bits; latency 5 with the macro.
- rst_n asserted with 3 beats in flight → out_valid = 0 immediately; seeds read back as defaults; the first post-reset beat gives the correct result.
